serial_rx_adder: RTL and testbench
==================================

SERIAL_RX_ADDER -- requirements
Module: serial_rx_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/sum width in bits (legal 2..32).
REQ-002 Port: clock  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  qualifies the current bit as bit 0 (LSB) of a new frame.
REQ-005 Port: a_bit  input  1  serial operand A bit, LSB first.
REQ-006 Port: b_bit  input  1  serial operand B bit, LSB first.
REQ-007 Port: cin  input  1  frame carry-in, sampled only with the start bit.
REQ-008 Port: bit_valid  input  1  a_bit/b_bit/start/cin valid this cycle.
REQ-009 Port: bit_ready  output  1  block accepts a bit this cycle; a bit transfers when bit_valid && bit_ready.
REQ-010 Port: sum  output  WIDTH  parallel sum, bit 0 = first received bit.
REQ-011 Port: cout  output  1  carry out of the MSB.
REQ-012 Port: sum_valid  output  1  sum/cout hold a completed result.
REQ-013 Port: sum_ready  input  1  consumer accepts the result; transfer when sum_valid && sum_ready.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT, HOLD.
REQ-015 bit_ready SHALL be 1 in IDLE and SHIFT, and 0 in HOLD.
REQ-016 IDLE: a transferred bit with start=0 SHALL be discarded; with start=1 it SHALL become bit 0, with carry seed cin, count=1, next state SHIFT.
REQ-017 Each accepted bit SHALL be added with the stored carry; the sum bit SHALL shift into sum[WIDTH-1] while sum shifts right by one; the carry register SHALL take the bit's carry-out.
REQ-018 SHIFT: a transferred bit with start=1 SHALL abort the current frame and restart it as bit 0, per REQ-016.
REQ-019 On the WIDTH-th accepted bit, the FSM SHALL go to HOLD, with sum_valid=1 in the next cycle (latency 1 cycle after the last bit), and sum aligned LSB at bit 0.
REQ-020 HOLD: sum, cout and sum_valid SHALL stay stable until sum_ready=1; on that transfer the next state SHALL be IDLE with sum_valid=0.
REQ-021 Cycles with bit_valid=0 SHALL leave all state unchanged (stalls allowed mid-frame).
REQ-022 Arithmetic SHALL be unsigned modulo 2^WIDTH; the overflow SHALL appear only on cout.
REQ-023 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL never exceed WIDTH.

Reset
REQ-024 reset=1 at a rising clock edge SHALL force IDLE, sum=0, cout=0, sum_valid=0, carry=0 and count=0, overriding every other input, including mid-frame and in HOLD.
REQ-025 After reset, bit_ready SHALL be 1 in the first cycle.

Configuration
REQ-026 With SERIAL_RX_SUB_EN defined, the block SHALL add an input port sub (1 bit, sampled with the start bit and held for the frame); when sub=1, b_bit SHALL be inverted before the adder and the carry seed SHALL be 1, ignoring cin, so that sum = A-B and cout = no-borrow.
REQ-027 Without SERIAL_RX_SUB_EN, the sub port SHALL be absent and the behaviour SHALL be addition only.

Structure
REQ-028 Package serial_rx_pkg SHALL hold the state enum (IDLE, SHIFT, HOLD) and the default WIDTH constant.
REQ-029 The 1-bit full adder SHALL be a gate-level sub-module full_adder_1b (a, b, ci -> s, co), instantiated once.

Verification
REQ-030 Scenario: WIDTH=8, A=8'd100, B=8'd27, cin=0, bits on 8 consecutive cycles, sum_ready=1 -> sum=8'd127, cout=0, sum_valid high for 1 cycle, one cycle after bit 7.
REQ-031 Scenario: A=8'hFF, B=8'h01, cin=1 -> sum=8'h01, cout=1.
REQ-032 Scenario: A=8'd50, B=8'd60 with bit_valid low on alternate cycles, sum_ready=0 for 5 cycles -> sum=8'd110 held stable, bit_ready=0 throughout HOLD.
REQ-033 Scenario: start re-asserted at bit 4 of a frame, then a full new frame A=8'd3, B=8'd4 -> sum=8'd7, with no result from the aborted frame.
REQ-034 Scenario: reset pulsed at bit 5, and separately in HOLD -> next cycle sum_valid=0, sum=0, bit_ready=1; bits with start=0 in IDLE are ignored.
REQ-035 Scenario (SERIAL_RX_SUB_EN): A=8'd10, B=8'd3, sub=1 -> sum=8'd7, cout=1; A=8'd3, B=8'd10 -> sum=8'd249, cout=0.

Source files
------------

// File: rtl/serial_rx_pkg.sv
// serial_rx_pkg: shared FSM state encoding and default operand width for the serial adder.
package serial_rx_pkg;
    localparam int DEFAULT_WIDTH = 8;
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
endpackage

// File: rtl/serial_rx_adder_if.sv
// serial_rx_adder_if: serial bit input handshake and parallel result handshake.
interface serial_rx_adder_if import serial_rx_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH);
    logic             start;
    logic             a_bit;
    logic             b_bit;
    logic             cin;
    logic             bit_valid;
    logic             bit_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             sum_valid;
    logic             sum_ready;
    modport master (output start, a_bit, b_bit, cin, bit_valid, sum_ready,
                    input  bit_ready, sum, cout, sum_valid);
    modport slave  (input  start, a_bit, b_bit, cin, bit_valid, sum_ready,
                    output bit_ready, sum, cout, sum_valid);
endinterface

// File: rtl/full_adder_1b.sv
// full_adder_1b: gate-level one-bit full adder.
module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic ab, t1, t2;
    xor g0 (ab, a, b);
    xor g1 (s, ab, ci);
    and g2 (t1, a, b);
    and g3 (t2, ab, ci);
    or  g4 (co, t1, t2);
endmodule

// File: rtl/serial_rx_adder.sv
// serial_rx_adder: LSB-first bit-serial adder producing a parallel sum and carry-out.
// Define SERIAL_RX_SUB_EN to add a per-frame sub input that turns the frame into A-B.
module serial_rx_adder import serial_rx_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic clock,
    input logic reset,
`ifdef SERIAL_RX_SUB_EN
    input logic sub,
`endif
    serial_rx_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    state_t           state, state_n;
    logic [CW-1:0]    count, count_n;
    logic [WIDTH-1:0] sum_q;
    logic             carry, cout_q, sub_eff, fa_ci, fa_s, fa_co, accept, last;
`ifdef SERIAL_RX_SUB_EN
    logic sub_q;
    // sub is latched with the start bit so it governs the whole frame
    assign sub_eff = bus.start ? sub : sub_q;
    always_ff @(posedge clock)
        if (reset)
            sub_q <= 1'b0;
        else if (accept && bus.start)
            sub_q <= sub;
`else
    assign sub_eff = 1'b0;
`endif
    assign fa_ci   = bus.start ? (sub_eff | bus.cin) : carry;
    assign accept  = bus.bit_valid && bus.bit_ready && (bus.start || state == SHIFT);
    assign count_n = bus.start ? CW'(1) : count + CW'(1);
    assign last    = count_n == CW'(WIDTH);
    full_adder_1b fa (
        .a  (bus.a_bit),
        .b  (bus.b_bit ^ sub_eff),
        .ci (fa_ci),
        .s  (fa_s),
        .co (fa_co)
    );
    always_comb begin
        state_n       = state;
        bus.bit_ready = state != HOLD;
        bus.sum_valid = state == HOLD;
        state_n       = (state == HOLD) ? (bus.sum_ready ? IDLE : HOLD)
                      : accept ? (last ? HOLD : SHIFT) : state;
    end
    always_ff @(posedge clock)
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    always_ff @(posedge clock)
        if (reset) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            carry  <= 1'b0;
            count  <= '0;
        end else if (accept) begin
            sum_q  <= {fa_s, sum_q[WIDTH-1:1]};
            carry  <= fa_co;
            count  <= count_n;
            cout_q <= last ? fa_co : cout_q;
        end else if (state == HOLD && bus.sum_ready) begin
            count <= '0;
        end
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_rx_adder.sv
// tb_serial_rx_adder: directed and random frames, scoreboard-checked against an arithmetic model.
module tb_serial_rx_adder;
    import serial_rx_pkg::*;
    localparam int W = DEFAULT_WIDTH;
    logic clock = 0;
    logic reset = 1;
`ifdef SERIAL_RX_SUB_EN
    logic sub = 0;
`endif
    serial_rx_adder_if #(.WIDTH(W)) bus ();
    serial_rx_adder #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
`ifdef SERIAL_RX_SUB_EN
        .sub   (sub),
`endif
        .bus   (bus)
    );
    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;
    bit rnd_ready = 0;
    logic [W:0] exp_q[$];
    logic [W:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // {cout, sum} from plain integer arithmetic; subtraction adds 2^W so cout means no borrow
    function automatic logic [W:0] model(input logic [W-1:0] a, b, input logic c, sb);
        longint r;
        r = sb ? longint'(a) - longint'(b) + (longint'(1) << W)
               : longint'(a) + longint'(b) + longint'(c);
        return r[W:0];
    endfunction

    always @(negedge clock)
        if (!reset && bus.sum_valid && bus.sum_ready) begin
            if (exp_q.size() == 0) chk("unexpected_result", bus.sum_valid, 0);
            else begin
                mon_e = exp_q.pop_front();
                chk("sum", bus.sum, mon_e[W-1:0]);
                chk("cout", bus.cout, mon_e[W]);
            end
        end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.bit_ready && n < 200) begin
            if (rnd_ready) bus.sum_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        chk("bit_ready_wait", bus.bit_ready, 1);
    endtask

    task automatic send_bits(input logic [W-1:0] a, b, input logic c, sb, input int n, input int stall_pct);
        for (int i = 0; i < n; i++) begin
            if (int'($urandom_range(0, 99)) < stall_pct) begin
                bus.bit_valid = 0;
                bus.start = 1'($urandom_range(0, 1));
                bus.a_bit = 1'($urandom_range(0, 1));
                bus.b_bit = 1'($urandom_range(0, 1));
                tick();
            end
            wait_ready();
            if (rnd_ready) bus.sum_ready = 1'($urandom_range(0, 1));
            bus.bit_valid = 1;
            bus.start = (i == 0);
            bus.a_bit = a[i];
            bus.b_bit = b[i];
            bus.cin = (i == 0) ? c : 1'($urandom_range(0, 1));
`ifdef SERIAL_RX_SUB_EN
            sub = (i == 0) ? sb : 1'($urandom_range(0, 1));
`endif
            tick();
            bus.bit_valid = 0;
            bus.start = 0;
        end
    endtask

    task automatic send_frame(input logic [W-1:0] a, b, input logic c, sb, input int stall_pct, input bit expect_result);
        send_bits(a, b, c, sb, W, stall_pct);
        if (expect_result) exp_q.push_back(model(a, b, c, sb));
    endtask

    initial begin
        logic rs;
        int n;
        bus.start = 0; bus.a_bit = 0; bus.b_bit = 0; bus.cin = 0;
        bus.bit_valid = 0; bus.sum_ready = 1;
        repeat (2) @(posedge clock);
        #1;
        reset = 0;
        chk("rst_bit_ready", bus.bit_ready, 1);
        chk("rst_sum_valid", bus.sum_valid, 0);
        chk("rst_sum", bus.sum, 0);
        chk("rst_cout", bus.cout, 0);

        send_frame(8'd100, 8'd27, 0, 0, 0, 1);
        chk("latency_valid", bus.sum_valid, 1);
        tick();
        chk("valid_one_cycle", bus.sum_valid, 0);

        send_frame(8'hFF, 8'h01, 1, 0, 0, 1);
        tick();

        // result held while the consumer stalls, new bits refused
        bus.sum_ready = 0;
        send_frame(8'd50, 8'd60, 0, 0, 100, 1);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", bus.sum_valid, 1);
            chk("hold_sum", bus.sum, 110);
            chk("hold_cout", bus.cout, 0);
            chk("hold_bit_ready", bus.bit_ready, 0);
            bus.bit_valid = 1; bus.start = 1; bus.a_bit = 1; bus.b_bit = 1;
            tick();
        end
        bus.bit_valid = 0; bus.start = 0;
        bus.sum_ready = 1;
        tick();
        chk("hold_release", bus.sum_valid, 0);

        send_bits(8'hAA, 8'h55, 0, 0, 4, 0);
        send_frame(8'd3, 8'd4, 0, 0, 0, 1);
        tick();

        send_bits(8'hF0, 8'h0F, 1, 0, 5, 0);
        reset = 1;
        tick();
        reset = 0;
        chk("midrst_valid", bus.sum_valid, 0);
        chk("midrst_sum", bus.sum, 0);
        chk("midrst_bit_ready", bus.bit_ready, 1);
        for (int i = 0; i < W; i++) begin
            bus.bit_valid = 1; bus.start = 0;
            bus.a_bit = 1'($urandom_range(0, 1));
            bus.b_bit = 1'($urandom_range(0, 1));
            tick();
        end
        bus.bit_valid = 0;
        chk("idle_ignore_valid", bus.sum_valid, 0);
        chk("idle_ignore_sum", bus.sum, 0);
        send_frame(8'd9, 8'd9, 0, 0, 0, 1);
        tick();

        bus.sum_ready = 0;
        send_frame(8'd200, 8'd100, 1, 0, 0, 0);
        chk("pre_hold_rst_valid", bus.sum_valid, 1);
        reset = 1;
        tick();
        reset = 0;
        chk("holdrst_valid", bus.sum_valid, 0);
        chk("holdrst_sum", bus.sum, 0);
        chk("holdrst_cout", bus.cout, 0);
        chk("holdrst_bit_ready", bus.bit_ready, 1);
        bus.sum_ready = 1;

`ifdef SERIAL_RX_SUB_EN
        send_frame(8'd10, 8'd3, 0, 1, 0, 1);
        tick();
        send_frame(8'd3, 8'd10, 1, 1, 0, 1);
        tick();
`endif

        rnd_ready = 1;
        repeat (30) begin
            rs = 0;
`ifdef SERIAL_RX_SUB_EN
            rs = 1'($urandom_range(0, 1));
`endif
            send_frame(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), rs, 30, 1);
        end
        rnd_ready = 0;
        bus.sum_ready = 1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        tick();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
